// File: rtl/inst_fetch_if.sv
// Instruction-cache request/response port: fetch stage is the master, cache the slave.
interface inst_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one cache read per PC, stalls the PC until the word returns,
// buffers it under downstream stall and drains responses orphaned by a flush.
module inst_fetch (
  input  logic              clk,
  input  logic              resetn,
  input  logic [64:0]       pc_to_ic_bus,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic              stallreq_if,
  inst_fetch_if.master      cache,
  output logic [96:0]       ic_to_id_bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_CANCEL
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] inst_buf;
  logic [31:0] excepttype;
  logic        ce;
  logic [31:0] pc;
  logic        need;
  logic        entry_avail;
  logic [96:0] entry;
  logic        unused_stall_bits;

  assign excepttype        = pc_to_ic_bus[64:33];
  assign ce                = pc_to_ic_bus[32];
  assign pc                = pc_to_ic_bus[31:0];
  assign need              = ce && (excepttype == '0);
  assign cache.inst_addr   = pc;
  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  always_comb begin
    next_state     = state;
    entry_avail    = 1'b0;
    entry          = '0;
    cache.inst_req = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cache.inst_req = need;
        if (!need) begin
          entry_avail = 1'b1;
          entry       = {excepttype, pc, 32'h0, ce};
        end else begin
          next_state = cache.inst_addr_ok ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        cache.inst_req = 1'b1;
        if (cache.inst_addr_ok) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache.inst_data_ok) begin
          entry_avail = 1'b1;
          entry       = {excepttype, pc, cache.inst_rdata, 1'b1};
          next_state  = stall[1] ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        entry_avail = 1'b1;
        entry       = {excepttype, pc, inst_buf, 1'b1};
        if (!stall[1]) next_state = ST_IDLE;
      end
      ST_CANCEL: begin
        if (cache.inst_data_ok) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    // An accepted request must still have its response drained; an unaccepted one is simply withdrawn.
    if (flush) begin
      unique case (state)
        ST_IDLE, ST_REQ: next_state = (cache.inst_req && cache.inst_addr_ok) ? ST_CANCEL : ST_IDLE;
        ST_WAIT:         next_state = cache.inst_data_ok ? ST_IDLE : ST_CANCEL;
        ST_DONE:         next_state = ST_IDLE;
        default:         next_state = cache.inst_data_ok ? ST_IDLE : ST_CANCEL;
      endcase
    end

    stallreq_if = !flush && !entry_avail && (need || (state == ST_CANCEL));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      inst_buf     <= '0;
      ic_to_id_bus <= '0;
    end else begin
      state <= next_state;
      if ((state == ST_WAIT) && cache.inst_data_ok && stall[1] && !flush)
        inst_buf <= cache.inst_rdata;
      if (flush)
        ic_to_id_bus <= '0;
      else if (!stall[1])
        ic_to_id_bus <= entry;
      else if (!stall[2])
        ic_to_id_bus <= '0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic [64:0] pc_to_ic_bus;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq_if;
  logic [96:0] ic_to_id_bus;

  inst_fetch_if cache ();

  inst_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_to_ic_bus (pc_to_ic_bus),
    .stall        (stall),
    .flush        (flush),
    .stallreq_if  (stallreq_if),
    .cache        (cache),
    .ic_to_id_bus (ic_to_id_bus)
  );

  always #5 clk = ~clk;

  localparam logic [64:0] P0 = {32'h0, 1'b0, 32'hbfc00000};
  localparam logic [64:0] PN = {32'h0, 1'b1, 32'hbfc00000};
  localparam logic [64:0] PA = {32'h00010000, 1'b1, 32'hbfc00002};
  localparam logic [64:0] PS = {32'h0, 1'b1, 32'hbfc00004};
  localparam logic [64:0] PH = {32'h0, 1'b1, 32'hbfc00008};
  localparam logic [64:0] PF = {32'h0, 1'b1, 32'hbfc0000c};
  localparam logic [64:0] PV = {32'h0, 1'b1, 32'hbfc00380};
  localparam logic [64:0] PR = {32'h0, 1'b1, 32'hbfc00010};

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // transaction-level model state
  logic        m_valid = 1'b0;
  logic [96:0] m_out   = '0;
  logic        m_acc   = 1'b0;  // request accepted, word not yet returned
  logic        m_have  = 1'b0;  // word returned, waiting for downstream
  logic [31:0] m_word  = '0;
  logic        m_drain = 1'b0;  // a stale response still owed by the cache
  logic        c_out   = 1'b0;  // cache side: one read outstanding
  logic        c_req, c_sreq;

  task automatic chk(input string nm, input logic [96:0] act, input logic [96:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic rn, input logic fl, input logic [64:0] pcb,
                       input logic ao, input logic dok, input logic [31:0] rd,
                       input logic hold);
    logic        need, has, e_req, e_sreq, ao_a, do_a;
    logic [96:0] ent;
    logic [31:0] exc, pc;
    logic        ce;
    resetn             = rn;
    flush              = fl;
    pc_to_ic_bus       = pcb;
    cache.inst_data_ok = dok && c_out;
    cache.inst_rdata   = rd;
    #1;
    cache.inst_addr_ok = ao && cache.inst_req;
    #1;
    if (fl)               stall = 6'b000000;
    else if (stallreq_if) stall = 6'b000011;
    else if (hold)        stall = 6'b000111;
    else                  stall = 6'b000000;
    #1;
    ao_a = cache.inst_addr_ok;
    do_a = cache.inst_data_ok;
    exc  = pcb[64:33];
    ce   = pcb[32];
    pc   = pcb[31:0];
    need = ce && (exc == 32'h0);
    has  = 1'b0;
    ent  = '0;
    if (m_drain) has = 1'b0;
    else if (!need) begin has = 1'b1; ent = {exc, pc, 32'h0, ce}; end
    else if (m_have) begin has = 1'b1; ent = {exc, pc, m_word, 1'b1}; end
    else if (m_acc && do_a) begin has = 1'b1; ent = {exc, pc, rd, 1'b1}; end
    e_req  = need && !m_acc && !m_have && !m_drain;
    e_sreq = !fl && !has && (need || m_drain);
    c_req  = cache.inst_req;
    c_sreq = stallreq_if;
    if (m_valid) begin
      chk("inst_req", {96'h0, cache.inst_req}, {96'h0, e_req});
      chk("stallreq_if", {96'h0, stallreq_if}, {96'h0, e_sreq});
      chk("inst_addr", {65'h0, cache.inst_addr}, {65'h0, pc});
      chk("ic_to_id_bus", ic_to_id_bus, m_out);
    end
    if (!rn) begin
      m_out = '0; m_acc = 1'b0; m_have = 1'b0; m_drain = 1'b0; m_valid = 1'b1;
    end else if (fl) begin
      m_out = '0;
      if (m_drain) begin
        if (do_a) m_drain = 1'b0;
      end else if ((m_acc && !do_a) || (e_req && ao_a)) begin
        m_drain = 1'b1;
      end
      m_acc  = 1'b0;
      m_have = 1'b0;
    end else begin
      if (!stall[1])      m_out = has ? ent : '0;
      else if (!stall[2]) m_out = '0;
      if (m_drain && do_a)     m_drain = 1'b0;
      if (m_have && !stall[1]) m_have = 1'b0;
      if (m_acc && do_a) begin
        m_acc = 1'b0;
        if (stall[1]) begin m_have = 1'b1; m_word = rd; end
      end
      if (e_req && ao_a) m_acc = 1'b1;
    end
    if (!rn) c_out = 1'b0;
    else begin
      if (do_a) c_out = 1'b0;
      if (ao_a) c_out = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n, k;
    logic [64:0] pcb;
    logic [31:0] p;
    logic        rn, fl;
    cache.inst_addr_ok = 1'b0;
    cache.inst_data_ok = 1'b0;
    cache.inst_rdata   = '0;
    stall              = '0;

    cycle(0, 0, P0, 0, 0, '0, 0);
    cycle(0, 0, P0, 0, 0, '0, 0);
    chk("reset_bus", ic_to_id_bus, '0);
    cycle(1, 0, P0, 0, 0, '0, 0);
    chk("reset_req", {96'h0, c_req}, '0);
    chk("reset_sreq", {96'h0, c_sreq}, '0);

    n = 0;
    cycle(1, 0, PN, 1, 0, '0, 0);              n += c_sreq;
    chk("normal_req", {96'h0, c_req}, 97'h1);
    cycle(1, 0, PN, 0, 1, 32'h24080001, 0);    n += c_sreq;
    chk("normal_stall_cycles", 97'(n), 97'd1);
    chk("normal_bus", ic_to_id_bus, {32'h0, 32'hbfc00000, 32'h24080001, 1'b1});

    cycle(1, 0, PA, 1, 1, '0, 0);
    chk("adel_req", {96'h0, c_req}, '0);
    chk("adel_stall", {96'h0, c_sreq}, '0);
    chk("adel_bus", ic_to_id_bus, {32'h00010000, 32'hbfc00002, 32'h0, 1'b1});

    n = 0; k = 0;
    repeat (3) begin cycle(1, 0, PS, 0, 0, '0, 0); n += c_sreq; k += c_req; end
    cycle(1, 0, PS, 1, 0, '0, 0);              n += c_sreq; k += c_req;
    cycle(1, 0, PS, 0, 0, '0, 0);              n += c_sreq;
    cycle(1, 0, PS, 0, 1, 32'h8c020010, 0);    n += c_sreq;
    chk("slow_stall_cycles", 97'(n), 97'd5);
    chk("slow_req_held", 97'(k), 97'd4);
    chk("slow_bus", ic_to_id_bus, {32'h0, 32'hbfc00004, 32'h8c020010, 1'b1});
    cycle(1, 0, P0, 0, 0, '0, 0);
    chk("slow_single_entry", {96'h0, ic_to_id_bus[0]}, '0);

    k = 0;
    cycle(1, 0, PH, 1, 0, '0, 0);
    cycle(1, 0, PH, 1, 1, 32'h24080001, 1);    k += c_req;
    repeat (3) begin cycle(1, 0, PH, 1, 0, '0, 1); k += c_req; end
    chk("hold_bus_held", ic_to_id_bus, '0);
    cycle(1, 0, PH, 1, 0, '0, 0);              k += c_req;
    chk("hold_no_reread", 97'(k), '0);
    chk("hold_bus", ic_to_id_bus, {32'h0, 32'hbfc00008, 32'h24080001, 1'b1});

    cycle(1, 0, PF, 1, 0, '0, 0);
    cycle(1, 1, PF, 0, 0, '0, 0);
    chk("flush_bus", ic_to_id_bus, '0);
    cycle(1, 0, PV, 1, 1, 32'hdeadbeef, 0);
    chk("cancel_req", {96'h0, c_req}, '0);
    chk("cancel_sreq", {96'h0, c_sreq}, 97'h1);
    chk("cancel_bus", ic_to_id_bus, '0);
    cycle(1, 0, PV, 1, 0, '0, 0);
    chk("refetch_req", {96'h0, c_req}, 97'h1);
    cycle(1, 0, PV, 0, 1, 32'h3c1a0000, 0);
    chk("flush_new_bus", ic_to_id_bus, {32'h0, 32'hbfc00380, 32'h3c1a0000, 1'b1});

    cycle(1, 0, PR, 1, 0, '0, 0);
    cycle(0, 0, PR, 0, 0, '0, 0);
    chk("rst_wait_bus", ic_to_id_bus, '0);
    cycle(1, 0, P0, 0, 1, 32'h55555555, 0);
    chk("rst_wait_req", {96'h0, c_req}, '0);
    chk("rst_wait_sreq", {96'h0, c_sreq}, '0);
    cycle(1, 0, PR, 1, 0, '0, 0);
    chk("rst_idle_req", {96'h0, c_req}, 97'h1);
    cycle(1, 0, PR, 0, 1, 32'h11112222, 0);
    chk("rst_refetch_bus", ic_to_id_bus, {32'h0, 32'hbfc00010, 32'h11112222, 1'b1});

    pcb = P0;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 63) != 0);
      fl = ($urandom_range(0, 15) == 0);
      cycle(rn, fl, pcb, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
            $urandom, ($urandom_range(0, 3) == 0));
      if (!rn) pcb = P0;
      else if (fl) pcb = PV;
      else if (!stall[0]) begin
        p = 32'hbfc00000 | ($urandom & 32'h0000fffc);
        case ($urandom_range(0, 7))
          0:       pcb = {32'h0, 1'b0, p};
          1:       pcb = {32'h00010000, 1'b1, p | 32'h2};
          default: pcb = {32'h0, 1'b1, p};
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage directly downstream of the PC register. It consumes the PC stage's `{excepttype, ce, pc}` bus and issues one read per PC on the SRAM-like instruction-cache port. It stalls the PC through the stall controller until the word returns, then presents `{excepttype, pc, inst, valid}` to ID through a stallable pipeline register. It also discards in-flight responses after a flush.

## Interface
Parameters: none; all widths fixed.

- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `pc_to_ic_bus` in 65: `[64:33]` excepttype, `[32]` ce, `[31:0]` pc.
- `stall` in 6: from ctrl.
  - `[1]=1` holds the IF output register.
  - `[2]` is the ID hold bit.
- `flush` in 1: exception/eret flush from ctrl.
- `stallreq_if` out 1: combinational stall request to ctrl. Ctrl maps it to `stall=6'b000011`.
- `inst_req` out 1: cache read request.
- `inst_addr` out 32: request address, equal to pc.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle.
- `inst_rdata` in 32: read data.
- `ic_to_id_bus` out 97 (registered):
  - `[96:65]` excepttype
  - `[64:33]` pc
  - `[32:1]` inst
  - `[0]` valid

## Operation
- `need` = `ce && excepttype==0`. An adel or ce=0 PC never touches the cache.
- Local entry without a cache access:
  - Applies when `ce && excepttype!=0`, or when `ce==0`.
  - Entry is `{excepttype, pc, 32'h0, ce}`.
  - It is available immediately in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL. Reset state is IDLE.
- IDLE
  - `inst_req=need`.
  - With need and addr_ok: go to WAIT. With need and no addr_ok: go to REQ.
  - Without need: the local entry is available and the state stays IDLE.
- REQ: `inst_req=1`. On addr_ok go to WAIT.
- WAIT
  - On data_ok: the entry is available with inst=`inst_rdata`.
  - If `stall[1]==0`, go to IDLE.
  - Otherwise latch rdata into `inst_buf` and go to DONE.
- DONE: the buffered entry is available. On `stall[1]==0` go to IDLE.
- CANCEL: `inst_req=0`. Discard the first data_ok, then go to IDLE. No entry is available in this state.
- `stallreq_if`:
  - Equals `!flush && !entry_available && (need || state==CANCEL)`.
  - `entry_available` = (WAIT && data_ok) || DONE || (IDLE && !need).
- Flush (dominant over all else):
  - Output register goes to 0.
  - IDLE/REQ with addr_ok this cycle: go to CANCEL.
  - IDLE/REQ without addr_ok: go to IDLE. The request is withdrawn, which the cache port permits before addr_ok.
  - WAIT with data_ok this cycle: go to IDLE and drop the data.
  - WAIT without data_ok: go to CANCEL.
  - DONE: go to IDLE. CANCEL: stays CANCEL until its data_ok arrives.
- Output register priority (highest first):
  - `!resetn` or flush: load 0.
  - `stall[1]==0`: load the available entry, or 0 if none.
  - `stall[1]==1 && stall[2]==0`: load 0 (bubble).
  - Otherwise hold.
- `inst_addr` is `pc` at all times. The PC is held stable by `stallreq_if` from request until the entry is consumed.

## Timing
- Reset outputs:
  - `ic_to_id_bus=0`, `inst_req=0`, `inst_buf=0`, state IDLE.
  - `stallreq_if=0`, since the PC stage resets with ce=0.
- Minimum latency is 2 cycles per instruction:
  - Request plus addr_ok in cycle 0.
  - data_ok in cycle 1; the entry is registered at the end of cycle 1.
  - The PC advances at the same edge.
- data_ok is never accepted in the same cycle as addr_ok for the same request.
- At most one outstanding cache transaction exists, including the CANCEL case. No new request is issued until the cancelled response drains.
- Downstream stall during data_ok: inst is held in DONE for as many cycles as needed, and the cache is not re-read.
- Reset mid-transaction returns to IDLE. The cache is reset in the same cycle, so no response is drained.

## Test plan
- **Normal fetch:** pc=0xbfc00000, ce=1; addr_ok in the req cycle; data_ok one cycle later with rdata=0x24080001. Required:
  - `stallreq_if=1` for 1 cycle.
  - The next cycle shows bus `{0, 0xbfc00000, 0x24080001, 1}`.
- **Slow handshake:** addr_ok delayed 3 cycles, data_ok delayed 2 more. Required:
  - `inst_req` is held with constant addr.
  - `stallreq_if=1` for 5 cycles, with exactly one entry emitted.
- **Downstream hold:** data_ok arrives while `stall=6'b000111` for 4 cycles. Required:
  - DONE holds 0x24080001.
  - The entry is emitted on the release cycle, with no second `inst_req`.
- **Flush in WAIT:** flush before data_ok, new pc=0xbfc00380. Required:
  - The stale data_ok (rdata=0xdeadbeef) is dropped.
  - The request for 0xbfc00380 starts only after it.
  - The output never carries 0xdeadbeef.
- **Adel:** pc=0xbfc00002 gives excepttype=0x00010000. Required:
  - No `inst_req`.
  - The entry `{0x00010000, 0xbfc00002, 0, 1}` appears with zero stall cycles.
- **Reset:** `resetn=0` mid-WAIT. Required: all outputs 0 and state IDLE on the next edge.
